// File: rtl/dmem_copy_engine.sv
// Data-memory block-copy engine: moves len words from src to dst, one RD/WR pair per word.
// Define DMA_FILL_EN to add fill mode (fill/fill_value ports), which writes a constant pattern.
module dmem_copy_engine #(
    parameter int DEPTH  = 128,
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W:0]   len,
`ifdef DMA_FILL_EN
    input  logic              fill,
    input  logic [WIDTH-1:0]  fill_value,
`endif
    output logic              busy,
    output logic              done,
    output logic              MemWrite,
    output logic [31:0]       MemAddr,
    output logic [WIDTH-1:0]  MemWData,
    input  logic [WIDTH-1:0]  MemRData
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] src_q, src_nxt;
    logic [ADDR_W-1:0] dst_q, dst_nxt;
    logic [ADDR_W:0]   len_q, len_nxt, len_sat;
    logic [ADDR_W:0]   idx, idx_nxt;
    logic [WIDTH-1:0]  data_buf, buf_nxt;
    logic              fill_q, fill_nxt;
    logic [WIDTH-1:0]  fv_q, fv_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [WIDTH-1:0]  wdata_nxt;

    assign len_sat = (len > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : len;

    // NOTE: every variable gets a default first so no path through the case infers a latch.
    always_comb begin
        state_nxt = state;
        src_nxt   = src_q;
        dst_nxt   = dst_q;
        len_nxt   = len_q;
        idx_nxt   = idx;
        buf_nxt   = data_buf;
        fill_nxt  = fill_q;
        fv_nxt    = fv_q;

        case (state)
            IDLE: begin
                if (start) begin
                    src_nxt = src;
                    dst_nxt = dst;
                    len_nxt = len_sat;
                    idx_nxt = '0;
`ifdef DMA_FILL_EN
                    fill_nxt = fill;
                    fv_nxt   = fill_value;
`else
                    fill_nxt = 1'b0;
`endif
                    if (len_sat == '0)
                        state_nxt = DONE;
                    else if (fill_nxt)
                        state_nxt = WR;
                    else
                        state_nxt = RD;
                end
            end
            RD: begin
                buf_nxt   = MemRData;
                state_nxt = WR;
            end
            WR: begin
                idx_nxt = idx + (ADDR_W+1)'(1);
                if (idx_nxt == len_q)
                    state_nxt = DONE;
                else if (fill_q)
                    state_nxt = WR;
                else
                    state_nxt = RD;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it (Moore).
        addr_nxt  = '0;
        wdata_nxt = '0;
        if (state_nxt == RD) begin
            addr_nxt = src_nxt + idx_nxt[ADDR_W-1:0];
        end else if (state_nxt == WR) begin
            addr_nxt  = dst_nxt + idx_nxt[ADDR_W-1:0];
            wdata_nxt = fill_nxt ? fv_nxt : buf_nxt;
        end
    end

    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            idx      <= '0;
            data_buf <= '0;
            fill_q   <= 1'b0;
            fv_q     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            MemWrite <= 1'b0;
            MemAddr  <= '0;
            MemWData <= '0;
        end else begin
            state    <= state_nxt;
            src_q    <= src_nxt;
            dst_q    <= dst_nxt;
            len_q    <= len_nxt;
            idx      <= idx_nxt;
            data_buf <= buf_nxt;
            fill_q   <= fill_nxt;
            fv_q     <= fv_nxt;
            busy     <= (state_nxt == RD) || (state_nxt == WR);
            done     <= (state_nxt == DONE);
            MemWrite <= (state_nxt == WR);
            MemAddr  <= {{(32-ADDR_W){1'b0}}, addr_nxt};
            MemWData <= wdata_nxt;
        end
    end

endmodule

// File: tb/tb_dmem_copy_engine.sv
// Self-checking bench for dmem_copy_engine: table vectors, random copies against a word-level
// reference memory, and hand sequences for reset mid-copy, ignored start and fill mode.
module tb_dmem_copy_engine;
    localparam int DEPTH  = 128;
    localparam int WIDTH  = 32;
    localparam int ADDR_W = 7;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] src, dst;
    logic [ADDR_W:0]   len;
    logic              fill;
    logic [WIDTH-1:0]  fill_value;
    logic              busy, done, MemWrite;
    logic [31:0]       MemAddr;
    logic [WIDTH-1:0]  MemWData, MemRData;

    logic [WIDTH-1:0]  mem     [DEPTH];
    logic [WIDTH-1:0]  ref_mem [DEPTH];
    logic              load_all = 1'b0;
    int                wr_total = 0;
    logic              hi_addr_err = 1'b0;
    logic              stray_wr = 1'b0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [ADDR_W-1:0] s;
        logic [ADDR_W-1:0] d;
        logic [ADDR_W:0]   l;
        int                lat;
        int                wr;
    } vec_t;
    vec_t vecs [6];

    always #5 clk = ~clk;

    dmem_copy_engine #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .src(src),
        .dst(dst),
        .len(len),
`ifdef DMA_FILL_EN
        .fill(fill),
        .fill_value(fill_value),
`endif
        .busy(busy),
        .done(done),
        .MemWrite(MemWrite),
        .MemAddr(MemAddr),
        .MemWData(MemWData),
        .MemRData(MemRData)
    );

    assign MemRData = mem[MemAddr[ADDR_W-1:0]];

    always @(posedge clk) begin
        if (load_all) begin
            for (int k = 0; k < DEPTH; k++) mem[k] <= ref_mem[k];
        end else if (MemWrite) begin
            mem[MemAddr[ADDR_W-1:0]] <= MemWData;
        end
        if (MemWrite) wr_total <= wr_total + 1;
        if (MemAddr[31:ADDR_W] != '0) hi_addr_err <= 1'b1;
        if (MemWrite && !busy) stray_wr <= 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_mem();
        @(negedge clk) load_all = 1'b1;
        @(negedge clk) load_all = 1'b0;
    endtask

    // Reference: sequential word-by-word copy (or fill) over a modulo-DEPTH address space.
    task automatic model_xfer(input int s, input int d, input int n, input bit f, input logic [31:0] fv);
        for (int k = 0; k < n; k++)
            ref_mem[(d + k) % DEPTH] = f ? fv : ref_mem[(s + k) % DEPTH];
    endtask

    task automatic compare_mem(input string name);
        int bad = 0;
        for (int k = 0; k < DEPTH; k++)
            if (mem[k] !== ref_mem[k]) bad++;
        check({name, ":mem"}, bad, 0);
    endtask

    task automatic do_xfer(input string name, input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                           input logic [ADDR_W:0] l, input bit f, input logic [31:0] fv,
                           input bit poke, input int exp_lat, input int exp_wr);
        int lat = 0, bcyc = 0, wcyc = 0, n;
        @(negedge clk);
        src = s; dst = d; len = l; fill = f; fill_value = fv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        src = ADDR_W'($urandom); dst = ADDR_W'($urandom); len = (ADDR_W+1)'($urandom);
        while (!done && lat < 400) begin
            if (busy) bcyc++;
            if (MemWrite) wcyc++;
            start = (poke && lat == 3);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check({name, ":done_lat"}, lat, exp_lat);
        check({name, ":busy_cycles"}, bcyc, exp_lat);
        check({name, ":writes"}, wcyc, exp_wr);
        check({name, ":busy_at_done"}, busy, 0);
        @(negedge clk);
        check({name, ":done_width"}, done, 0);
        n = (int'(l) > DEPTH) ? DEPTH : int'(l);
        model_xfer(int'(s), int'(d), n, f, fv);
        compare_mem(name);
    endtask

    initial begin
        int w0, n;
        logic [ADDR_W-1:0] rs, rd;
        logic [ADDR_W:0] rl;
        bit rf;
        logic [31:0] rv;

        vecs = '{
            '{7'd0,   7'd64, 8'd1,   2,   1},
            '{7'd5,   7'd5,  8'd3,   6,   3},
            '{7'd50,  7'd52, 8'd10,  20,  10},
            '{7'd100, 7'd20, 8'd128, 256, 128},
            '{7'd3,   7'd90, 8'd200, 256, 128},
            '{7'd9,   7'd9,  8'd0,   0,   0}
        };

        reset = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0; fill = 1'b0; fill_value = '0;
        for (int k = 0; k < DEPTH; k++) ref_mem[k] = $urandom;
        repeat (2) @(negedge clk);
        check("rst:busy", busy, 0);
        check("rst:done", done, 0);
        check("rst:memwrite", MemWrite, 0);
        check("rst:memaddr", MemAddr, 0);
        check("rst:memwdata", MemWData, 0);
        reset = 1'b0;
        push_mem();

        // Basic copy with known pattern.
        for (int k = 0; k < 4; k++) ref_mem[10 + k] = 32'hA0 + k;
        push_mem();
        do_xfer("basic", 7'd10, 7'd40, 8'd4, 1'b0, 32'h0, 1'b0, 8, 4);
        for (int k = 0; k < 4; k++) check("basic:word", mem[40 + k], 32'hA0 + k);

        for (int v = 0; v < 6; v++)
            do_xfer($sformatf("vec%0d", v), vecs[v].s, vecs[v].d, vecs[v].l, 1'b0, 32'h0, 1'b0,
                    vecs[v].lat, vecs[v].wr);

        // Wrapping source with forward overlap into the destination.
        ref_mem[126] = 1; ref_mem[127] = 2; ref_mem[0] = 3; ref_mem[1] = 4;
        push_mem();
        do_xfer("wrap", 7'd126, 7'd1, 8'd4, 1'b0, 32'h0, 1'b0, 8, 4);

        // Reset during the third word's WR of a six-word copy.
        w0 = wr_total;
        @(negedge clk);
        src = 7'd30; dst = 7'd70; len = 8'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst:in_wr", MemWrite, 1);
        reset = 1'b1;
        #1;
        check("midrst:busy", busy, 0);
        check("midrst:memwrite", MemWrite, 0);
        check("midrst:memaddr", MemAddr, 0);
        check("midrst:memwdata", MemWData, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrst:writes", wr_total - w0, 2);
        model_xfer(30, 70, 2, 1'b0, 32'h0);
        compare_mem("midrst");
        do_xfer("postrst", 7'd70, 7'd110, 8'd3, 1'b0, 32'h0, 1'b0, 6, 3);

        // A start pulse while busy is ignored.
        do_xfer("poke", 7'd60, 7'd90, 8'd8, 1'b0, 32'h0, 1'b1, 16, 8);

`ifdef DMA_FILL_EN
        do_xfer("fill", 7'd0, 7'd20, 8'd5, 1'b1, 32'hDEADBEEF, 1'b0, 5, 5);
        for (int k = 0; k < 5; k++) check("fill:word", mem[20 + k], 32'hDEADBEEF);
`endif

        for (int t = 0; t < 10; t++) begin
            rs = ADDR_W'($urandom);
            rd = ADDR_W'($urandom);
            rl = (ADDR_W+1)'($urandom_range(1, 40));
            rv = $urandom;
`ifdef DMA_FILL_EN
            rf = 1'($urandom_range(0, 1));
`else
            rf = 1'b0;
`endif
            n = int'(rl);
            do_xfer($sformatf("rand%0d", t), rs, rd, rl, rf, rv, 1'b0, rf ? n : 2 * n, n);
        end

        check("addr_high_bits", hi_addr_err, 0);
        check("write_outside_busy", stray_wr, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
